// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch sequencer between program counter, imem and decode.
// Optional macro FETCH_TIMEOUT_EN adds a FETCH wait timeout and fetch_err.
module fetch_ctrl #(
   parameter int INS_W   = 32,
   parameter int CNT_W   = 32,
   parameter int TIMEOUT = 16
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             start,
   input  logic             halt,
   output logic             imem_req,
   input  logic             imem_ack,
   input  logic [INS_W-1:0] imem_rdata,
   output logic             ins_valid,
   output logic [INS_W-1:0] ins_data,
   input  logic             ins_ready,
   input  logic             branch_valid,
   input  logic [INS_W-1:0] branch_offset,
   output logic             pc_en_cnt,
   output logic             pc_en_offset,
   output logic [INS_W-1:0] pc_offset,
   output logic             busy,
   output logic [1:0]       state_o,
   output logic [CNT_W-1:0] fetch_cnt,
   output logic             fetch_err
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_FETCH   = 2'd1,
      S_ISSUE   = 2'd2,
      S_ADVANCE = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [INS_W-1:0] r_ins;
   logic [CNT_W-1:0] r_cnt;
   logic             r_bpend;
   logic [INS_W-1:0] r_boff;
   logic             r_hpend;
   logic             w_go;
   logic             w_timeout;

   assign w_go = start & ~halt;

`ifdef FETCH_TIMEOUT_EN
   localparam int WW = $clog2(TIMEOUT + 1);

   logic [WW-1:0] r_wait;
   logic          r_err;

   assign w_timeout = (r_state == S_FETCH) && !imem_ack &&
                      (r_wait == WW'(TIMEOUT - 1));
   assign fetch_err = r_err;

   // Wait counter: zero outside FETCH, so every FETCH entry starts fresh
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         r_wait <= '0;
      else if (r_state != S_FETCH)
         r_wait <= '0;
      else if (!imem_ack)
         r_wait <= r_wait + WW'(1);
   end

   // Sticky error: set on timeout, cleared by an accepted start
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         r_err <= 1'b0;
      else if (w_timeout)
         r_err <= 1'b1;
      else if (r_state == S_IDLE && w_go)
         r_err <= 1'b0;
   end
`else
   logic w_unused_timeout;

   assign w_unused_timeout = (TIMEOUT > 0);
   assign w_timeout        = 1'b0;
   assign fetch_err        = 1'b0;
`endif

   assign ins_data  = r_ins;
   assign fetch_cnt = r_cnt;
   assign state_o   = r_state;

   // State register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         r_state <= S_IDLE;
      else
         r_state <= w_next;
   end

   // Next state and state-decoded outputs (no input-to-output paths)
   always_comb begin
      w_next       = r_state;
      imem_req     = 1'b0;
      ins_valid    = 1'b0;
      pc_en_cnt    = 1'b0;
      pc_en_offset = 1'b0;
      pc_offset    = '0;
      busy         = (r_state != S_IDLE);
      unique case (r_state)
         S_IDLE: begin
            if (w_go)
               w_next = S_FETCH;
         end
         S_FETCH: begin
            imem_req = 1'b1;
            if (imem_ack)
               w_next = S_ISSUE;
            else if (w_timeout)
               w_next = S_IDLE;
         end
         S_ISSUE: begin
            ins_valid = 1'b1;
            if (ins_ready)
               w_next = S_ADVANCE;
         end
         S_ADVANCE: begin
            if (r_bpend) begin
               pc_en_offset = 1'b1;
               pc_offset    = r_boff;
            end else begin
               pc_en_cnt = 1'b1;
            end
            if (r_hpend || halt)
               w_next = S_IDLE;
            else
               w_next = S_FETCH;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Latch the fetched word; hold it through ISSUE and beyond
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         r_ins <= '0;
      else if (r_state == S_FETCH && imem_ack)
         r_ins <= imem_rdata;
   end

   // Count instructions accepted by decode, wrapping naturally
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         r_cnt <= '0;
      else if (r_state == S_ISSUE && ins_ready)
         r_cnt <= r_cnt + CNT_W'(1);
   end

   // Branch capture: last wins; a new one in ADVANCE survives consumption
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_bpend <= 1'b0;
         r_boff  <= '0;
      end else if (r_state != S_IDLE && branch_valid) begin
         r_bpend <= 1'b1;
         r_boff  <= branch_offset;
      end else if (r_state == S_ADVANCE) begin
         r_bpend <= 1'b0;
      end
   end

   // Halt request held until the in-flight instruction has advanced
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         r_hpend <= 1'b0;
      else if (r_state == S_ADVANCE || w_timeout)
         r_hpend <= 1'b0;
      else if (r_state != S_IDLE && halt)
         r_hpend <= 1'b1;
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: table-driven vectors plus hand sequences for fetch_ctrl.
// Expected outputs go through a scoreboard queue; CNT_W=4 exercises wrap.
module tb_fetch_ctrl;

   localparam int IW = 32;
   localparam int CW = 4;

   logic          clock = 1'b0;
   logic          reset_n = 1'b0;
   logic          start = 1'b0;
   logic          halt = 1'b0;
   logic          imem_req;
   logic          imem_ack = 1'b0;
   logic [IW-1:0] imem_rdata = '0;
   logic          ins_valid;
   logic [IW-1:0] ins_data;
   logic          ins_ready = 1'b0;
   logic          branch_valid = 1'b0;
   logic [IW-1:0] branch_offset = '0;
   logic          pc_en_cnt;
   logic          pc_en_offset;
   logic [IW-1:0] pc_offset;
   logic          busy;
   logic [1:0]    state_o;
   logic [CW-1:0] fetch_cnt;
   logic          fetch_err;

   fetch_ctrl #(.INS_W(IW), .CNT_W(CW), .TIMEOUT(16)) dut (
      .clock(clock), .reset_n(reset_n), .start(start), .halt(halt),
      .imem_req(imem_req), .imem_ack(imem_ack),
      .imem_rdata(imem_rdata), .ins_valid(ins_valid),
      .ins_data(ins_data), .ins_ready(ins_ready),
      .branch_valid(branch_valid), .branch_offset(branch_offset),
      .pc_en_cnt(pc_en_cnt), .pc_en_offset(pc_en_offset),
      .pc_offset(pc_offset), .busy(busy), .state_o(state_o),
      .fetch_cnt(fetch_cnt), .fetch_err(fetch_err)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic          st, hl, ack;
      logic [IW-1:0] rd;
      logic          rdy, bv;
      logic [IW-1:0] bo;
      logic [1:0]    e_st;
      logic          e_ec, e_eo;
      logic [IW-1:0] e_off, e_id;
      logic [CW-1:0] e_fc;
      logic          e_err;
   } vec_t;

   vec_t tbl[37];
   vec_t sb[$];
   int   nvec = 0;
   int   nmis = 0;

   localparam logic [IW-1:0] J  = 32'hBAD0_BAD0;
   localparam logic [IW-1:0] A1 = 32'hA000_0001;
   localparam logic [IW-1:0] A2 = 32'hA000_0002;
   localparam logic [IW-1:0] A3 = 32'hA000_0003;
   localparam logic [IW-1:0] B1 = 32'hB000_0001;
   localparam logic [IW-1:0] B2 = 32'hB000_0002;
   localparam logic [IW-1:0] C1 = 32'hC000_0001;
   localparam logic [IW-1:0] C2 = 32'hC000_0002;
   localparam logic [IW-1:0] D1 = 32'hD000_0001;
   localparam logic [IW-1:0] E1 = 32'hE000_0001;
   localparam logic [IW-1:0] F1 = 32'hF000_0001;
   localparam logic [IW-1:0] W0 = 32'h5000_0000;

   function automatic vec_t mk(
      input logic s, h, a, input logic [IW-1:0] rd,
      input logic r, b, input logic [IW-1:0] bo,
      input logic [1:0] es, input logic ec, eo,
      input logic [IW-1:0] eoff, eid, input logic [CW-1:0] efc);
      vec_t v;
      v.st = s; v.hl = h; v.ack = a; v.rd = rd;
      v.rdy = r; v.bv = b; v.bo = bo;
      v.e_st = es; v.e_ec = ec; v.e_eo = eo;
      v.e_off = eoff; v.e_id = eid; v.e_fc = efc;
      v.e_err = 1'b0;
      return v;
   endfunction

   task automatic check(input vec_t e, input string nm);
      logic bad;
      bad = (state_o !== e.e_st) || (imem_req !== (e.e_st == 2'd1)) ||
            (ins_valid !== (e.e_st == 2'd2)) ||
            (busy !== (e.e_st != 2'd0)) ||
            (pc_en_cnt !== e.e_ec) || (pc_en_offset !== e.e_eo) ||
            (pc_offset !== e.e_off) || (ins_data !== e.e_id) ||
            (fetch_cnt !== e.e_fc) || (fetch_err !== e.e_err);
      nvec++;
      if (bad) begin
         nmis++;
         $display("FAIL %s: got st=%0d req=%b iv=%b busy=%b ec=%b eo=%b off=%h id=%h fc=%0d err=%b, want st=%0d ec=%b eo=%b off=%h id=%h fc=%0d err=%b",
                  nm, state_o, imem_req, ins_valid, busy, pc_en_cnt,
                  pc_en_offset, pc_offset, ins_data, fetch_cnt, fetch_err,
                  e.e_st, e.e_ec, e.e_eo, e.e_off, e.e_id, e.e_fc,
                  e.e_err);
      end
   endtask

   task automatic apply(input vec_t v, input string nm);
      vec_t e;
      @(negedge clock);
      start = v.st; halt = v.hl; imem_ack = v.ack;
      imem_rdata = v.rd; ins_ready = v.rdy;
      branch_valid = v.bv; branch_offset = v.bo;
      sb.push_back(v);
      #1;
      e = sb.pop_front();
      check(e, nm);
   endtask

   initial begin
      vec_t v;
      logic [IW-1:0] prev;
      logic [CW-1:0] fc;

      // sequential run, ack/ready tied high, 3 instructions
      tbl[0]  = mk(1,0,1,J ,1,0,0, 0,0,0,0,0 ,0);
      tbl[1]  = mk(0,0,1,A1,1,0,0, 1,0,0,0,0 ,0);
      tbl[2]  = mk(0,0,1,J ,1,0,0, 2,0,0,0,A1,0);
      tbl[3]  = mk(0,0,1,J ,1,0,0, 3,1,0,0,A1,1);
      tbl[4]  = mk(0,0,1,A2,1,0,0, 1,0,0,0,A1,1);
      tbl[5]  = mk(0,0,1,J ,1,0,0, 2,0,0,0,A2,1);
      tbl[6]  = mk(0,0,1,J ,1,0,0, 3,1,0,0,A2,2);
      tbl[7]  = mk(0,0,1,A3,1,0,0, 1,0,0,0,A2,2);
      tbl[8]  = mk(0,0,1,J ,1,0,0, 2,0,0,0,A3,2);
      tbl[9]  = mk(0,1,1,J ,1,0,0, 3,1,0,0,A3,3);
      tbl[10] = mk(0,0,0,J ,0,0,0, 0,0,0,0,A3,3);
      // branch 5 during ISSUE
      tbl[11] = mk(1,0,0,J ,0,0,0, 0,0,0,0,A3,3);
      tbl[12] = mk(0,0,1,B1,0,0,0, 1,0,0,0,A3,3);
      tbl[13] = mk(0,0,0,J ,1,1,5, 2,0,0,0,B1,3);
      tbl[14] = mk(0,0,0,J ,0,0,0, 3,0,1,5,B1,4);
      tbl[15] = mk(0,0,1,B2,0,0,0, 1,0,0,0,B1,4);
      tbl[16] = mk(0,0,0,J ,1,0,0, 2,0,0,0,B2,4);
      tbl[17] = mk(0,0,0,J ,0,0,0, 3,1,0,0,B2,5);
      // two branches (2 then 7), then one during ADVANCE (9)
      tbl[18] = mk(0,0,0,J ,0,1,2, 1,0,0,0,B2,5);
      tbl[19] = mk(0,0,1,C1,0,1,7, 1,0,0,0,B2,5);
      tbl[20] = mk(0,0,0,J ,1,0,0, 2,0,0,0,C1,5);
      tbl[21] = mk(0,0,0,J ,0,1,9, 3,0,1,7,C1,6);
      tbl[22] = mk(0,0,1,C2,0,0,0, 1,0,0,0,C1,6);
      tbl[23] = mk(0,0,0,J ,1,0,0, 2,0,0,0,C2,6);
      tbl[24] = mk(0,1,0,J ,0,0,0, 3,0,1,9,C2,7);
      tbl[25] = mk(0,0,0,J ,0,0,0, 0,0,0,0,C2,7);
      // halt pulse while FETCH waits 4 cycles
      tbl[26] = mk(1,0,0,J ,0,0,0, 0,0,0,0,C2,7);
      tbl[27] = mk(0,1,0,J ,0,0,0, 1,0,0,0,C2,7);
      tbl[28] = mk(0,0,0,J ,0,0,0, 1,0,0,0,C2,7);
      tbl[29] = mk(0,0,0,J ,0,0,0, 1,0,0,0,C2,7);
      tbl[30] = mk(0,0,1,D1,0,0,0, 1,0,0,0,C2,7);
      tbl[31] = mk(0,0,0,J ,0,0,0, 2,0,0,0,D1,7);
      tbl[32] = mk(0,0,0,J ,1,0,0, 2,0,0,0,D1,7);
      tbl[33] = mk(0,0,0,J ,0,0,0, 3,1,0,0,D1,8);
      // start with halt in IDLE is ignored
      tbl[34] = mk(1,1,0,J ,0,0,0, 0,0,0,0,D1,8);
      tbl[35] = mk(0,0,0,J ,0,0,0, 0,0,0,0,D1,8);
      tbl[36] = mk(0,0,0,J ,0,0,0, 0,0,0,0,D1,8);

      #3;
      check(mk(0,0,0,0,0,0,0, 0,0,0,0,0,0), "reset");
      @(negedge clock);
      reset_n = 1'b1;

      for (int i = 0; i < 37; i++)
         apply(tbl[i], $sformatf("tbl%0d", i));

      // reset while ISSUE holds a pending branch
      apply(mk(1,0,0,J ,0,0,0, 0,0,0,0,D1,8), "rst_a");
      apply(mk(0,0,1,E1,0,0,0, 1,0,0,0,D1,8), "rst_b");
      apply(mk(0,0,0,J ,0,1,3, 2,0,0,0,E1,8), "rst_c");
      apply(mk(0,0,0,J ,0,0,0, 2,0,0,0,E1,8), "rst_d");
      #2 reset_n = 1'b0;
      #1 check(mk(0,0,0,0,0,0,0, 0,0,0,0,0,0), "rst_async");
      @(negedge clock);
      reset_n = 1'b1;
      apply(mk(1,0,0,J ,0,0,0, 0,0,0,0,0 ,0), "rst_e");
      apply(mk(0,0,1,F1,0,0,0, 1,0,0,0,0 ,0), "rst_f");
      apply(mk(0,0,0,J ,1,0,0, 2,0,0,0,F1,0), "rst_g");
      apply(mk(0,0,0,J ,0,0,0, 3,1,0,0,F1,1), "rst_seq_adv");

      // fetch_cnt wrap 15 -> 0
      prev = F1;
      for (int i = 0; i < 15; i++) begin
         fc = CW'(1 + i);
         apply(mk(0,0,1,W0+i,0,0,0, 1,0,0,0,prev,fc), "wrap_f");
         apply(mk(0,0,0,J,1,0,0, 2,0,0,0,W0+i,fc), "wrap_i");
         apply(mk(0,i==14,0,J,0,0,0, 3,1,0,0,W0+i,fc+CW'(1)),
               $sformatf("wrap_a%0d", i));
         prev = W0 + i;
      end
      apply(mk(0,0,0,J,0,0,0, 0,0,0,0,prev,0), "wrap_idle");

`ifdef FETCH_TIMEOUT_EN
      apply(mk(1,0,0,J,0,0,0, 0,0,0,0,prev,0), "to_start");
      for (int i = 0; i < 16; i++)
         apply(mk(0,0,0,J,0,0,0, 1,0,0,0,prev,0), "to_wait");
      v = mk(1,0,0,J,0,0,0, 0,0,0,0,prev,0);
      v.e_err = 1'b1;
      apply(v, "to_err");
      apply(mk(0,1,1,E1,0,0,0, 1,0,0,0,prev,0), "to_clear");
      apply(mk(0,0,0,J,1,0,0, 2,0,0,0,E1,0), "to_issue");
      apply(mk(0,0,0,J,0,0,0, 3,1,0,0,E1,1), "to_adv");
      apply(mk(0,0,0,J,0,0,0, 0,0,0,0,E1,1), "to_idle");
`else
      v = mk(0,0,0,J,0,0,0, 0,0,0,0,prev,0);
      apply(v, "noto_idle");
`endif

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Fetch sequencer for the program counter block. Drives the counter's increment/offset enables, handshakes with instruction memory at the current count, and hands each fetched instruction to decode through a valid/ready interface. Latches branch offsets from execute and applies them at the next PC-advance slot. It sits between the program counter, instruction memory and decode.

Parameters:
INS_W, 32, instruction and offset width; matches `SZB_INS.
CNT_W, 32, fetch-count width; matches `BIT_CNT.
TIMEOUT, 16, cycles FETCH waits for imem_ack before error; used only with FETCH_TIMEOUT_EN.

Ports:
clock  in  1  system clock, rising edge.
reset_n  in  1  asynchronous, active-low reset.
start  in  1  begin fetching from IDLE.
halt  in  1  stop after the current instruction completes.
imem_req  out  1  read request to instruction memory; address is the counter's present pc_cnt.
imem_ack  in  1  read data valid.
imem_rdata  in  INS_W  instruction word.
ins_valid  out  1  instruction available to decode.
ins_data  out  INS_W  latched instruction.
ins_ready  in  1  decode accepts the instruction.
branch_valid  in  1  branch taken, one-cycle pulse.
branch_offset  in  INS_W  branch offset, passed through unmodified; the counter applies it.
pc_en_cnt  out  1  sequential-advance enable to the counter.
pc_en_offset  out  1  branch-advance enable to the counter.
pc_offset  out  INS_W  offset to the counter.
busy  out  1  state is not IDLE.
state_o  out  2  state: 0 IDLE, 1 FETCH, 2 ISSUE, 3 ADVANCE.
fetch_cnt  out  CNT_W  count of instructions accepted by decode.
fetch_err  out  1  sticky fetch timeout; tied 0 without FETCH_TIMEOUT_EN.

Behaviour:
- Reset (reset_n=0, async): state IDLE. All outputs 0. ins_data=0, fetch_cnt=0. branch_pend, halt_pend and branch_off_q all cleared. Reset mid-transaction abandons it at once; imem_req drops in the same cycle.
- All outputs are registered or decoded from state and registers only; there is no combinational input-to-output path.
- IDLE: if start=1 and halt=0, go to FETCH next cycle; halt wins over start. Otherwise stay.
- FETCH: imem_req=1. On imem_ack=1, latch imem_rdata into ins_data and go to ISSUE. The counter enables are held 0, so the address stays stable.
- ISSUE: ins_valid=1 and ins_data is held. On ins_ready=1, fetch_cnt increments and the state goes to ADVANCE. fetch_cnt wraps from 2^CNT_W-1 to 0.
- ADVANCE: lasts exactly one cycle.
  - If branch_pend=1: pc_en_offset=1, pc_offset=branch_off_q, pc_en_cnt=0, then clear branch_pend.
  - Otherwise: pc_en_cnt=1, pc_en_offset=0, pc_offset=0.
  - The two enables are never high together.
  - Next state is IDLE if halt_pend or halt is 1 (clear halt_pend), else FETCH.
- Branch capture: branch_valid=1 in any state except IDLE sets branch_pend and loads branch_off_q.
  - A second branch before it is consumed overwrites the first; last wins.
  - A branch arriving during ADVANCE is latched and applied at the following ADVANCE.
  - In IDLE, branch_valid is ignored.
- Halt: halt=1 in FETCH, ISSUE or ADVANCE sets halt_pend. The current instruction always completes fetch, issue and advance; a memory transaction is never abandoned.
- Outside ADVANCE: pc_en_cnt=0, pc_en_offset=0, pc_offset=0.
- Throughput: at best 3 cycles per instruction (FETCH with same-cycle ack, ISSUE with same-cycle ready, ADVANCE).

Optional Feature:
FETCH_TIMEOUT_EN. When defined:
- A wait counter runs in FETCH and clears on entry to FETCH.
- If TIMEOUT consecutive cycles pass in FETCH without imem_ack, set fetch_err, drop imem_req and go to IDLE. The PC is not advanced and fetch_cnt is unchanged.
- fetch_err is sticky and clears only on reset or on an accepted start in IDLE.
When undefined: FETCH waits indefinitely, fetch_err is constant 0 and no wait counter is built.

Test Plan:
- Reset then start pulse, imem_ack and ins_ready tied 1, 3 instructions: states cycle 1,2,3 per instruction; pc_en_cnt pulses once every 3 cycles; fetch_cnt reaches 3; pc_en_offset stays 0.
- branch_valid with branch_offset=0x00000005 during ISSUE: next ADVANCE gives pc_en_offset=1, pc_offset=5, pc_en_cnt=0; the following ADVANCE is sequential.
- Two branches, offsets 2 then 7, before ADVANCE: only offset 7 is applied. Branch pulsed during ADVANCE: applied at the next instruction's ADVANCE.
- halt asserted 1 cycle while FETCH waits 4 cycles for ack: the instruction still issues and advances, then IDLE, busy=0. start and halt together in IDLE: remains IDLE.
- reset_n low while in ISSUE with branch pending: immediate IDLE, ins_valid=0, branch_pend cleared; after restart the first ADVANCE is sequential.
- FETCH_TIMEOUT_EN, TIMEOUT=16, ack never given: after 16 FETCH cycles fetch_err=1, IDLE, no enable pulse; the next start clears fetch_err. Also preload fetch_cnt wrap: 2^CNT_W-1 plus one accept gives 0.
